// File: rtl/rp_scope_calib_ctrl_pkg.sv
// Shared types and constants for the scope channel auto-offset calibration sequencer.
package rp_scope_calib_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_CALC   = 3'd3,
        ST_APPLY  = 3'd4
    } state_t;

    localparam logic [15:0] GAIN_UNITY = 16'h8000;
    localparam int          WDOG_LIMIT = 65535;

    // Largest positive value of a signed word of the given width.
    function automatic longint sat_max(input int dbits);
        return (longint'(1) <<< (dbits - 1)) - 1;
    endfunction

    // Most negative value of a signed word of the given width.
    function automatic longint sat_min(input int dbits);
        return -(longint'(1) <<< (dbits - 1));
    endfunction

endpackage

// File: rtl/rp_scope_calib_ctrl_if.sv
// Control/status bundle between the register bank / ADC front end and the calibration sequencer.
interface rp_scope_calib_ctrl_if #(
    parameter int DBITS       = 16,
    parameter int SETTLE_BITS = 16
);
    logic signed [DBITS-1:0]       adc_dat_i;
    logic                          adc_tvalid_i;
    logic                          start_i;
    logic                          abort_i;
    logic                          load_man_i;
    logic [4:0]                    cfg_avg_log2_i;
    logic [SETTLE_BITS-1:0]        cfg_settle_i;
    logic signed [DBITS-1:0]       cfg_offset_man_i;
    logic [15:0]                   cfg_gain_i;
    logic signed [DBITS-1:0]       cfg_calib_offset_o;
    logic [15:0]                   cfg_calib_gain_o;
    logic signed [DBITS-1:0]       meas_avg_o;
    logic                          busy_o;
    logic                          done_o;
    logic                          err_o;

    modport master (
        output adc_dat_i, adc_tvalid_i, start_i, abort_i, load_man_i,
               cfg_avg_log2_i, cfg_settle_i, cfg_offset_man_i, cfg_gain_i,
        input  cfg_calib_offset_o, cfg_calib_gain_o, meas_avg_o, busy_o, done_o, err_o
    );

    modport slave (
        input  adc_dat_i, adc_tvalid_i, start_i, abort_i, load_man_i,
               cfg_avg_log2_i, cfg_settle_i, cfg_offset_man_i, cfg_gain_i,
        output cfg_calib_offset_o, cfg_calib_gain_o, meas_avg_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/rp_scope_calib_ctrl_acc.sv
// Sample accumulator: sums 2^N valid samples and presents the floor average (acc >>> N).
module rp_scope_calib_acc #(
    parameter int DBITS        = 16,
    parameter int ACC_LOG2_MAX = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic                    i_tvalid,
    input  logic signed [DBITS-1:0] i_dat,
    input  logic [4:0]              i_n,
    output logic                    o_last,
    output logic signed [DBITS-1:0] o_avg
);
    localparam int AW = DBITS + ACC_LOG2_MAX;
    localparam int CW = ACC_LOG2_MAX + 1;

    logic signed [AW-1:0] r_acc;
    logic [CW-1:0]        r_cnt;
    logic                 w_take;
    logic [CW-1:0]        w_cnt_inc;
    logic [CW-1:0]        w_target;
    logic signed [AW-1:0] w_dat_ext;

    assign w_take    = i_en & i_tvalid;
    assign w_cnt_inc = r_cnt + CW'(1);
    // N never exceeds ACC_LOG2_MAX, so 2^N fits in CW bits.
    assign w_target  = CW'(1) << i_n;
    assign w_dat_ext = {{ACC_LOG2_MAX{i_dat[DBITS-1]}}, i_dat};
    assign o_last    = w_take && (w_cnt_inc == w_target);
    // The mean of DBITS-wide samples always fits back in DBITS bits.
    assign o_avg     = DBITS'(r_acc >>> i_n);

    // Accumulate sign-extended samples; tvalid low simply holds the sum and count.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_take) begin
            r_acc <= r_acc + w_dat_ext;
            r_cnt <= w_cnt_inc;
        end
    end
endmodule

// File: rtl/rp_scope_calib_ctrl.sv
// Auto-offset calibration sequencer for one scope channel.
// Optional build macro RP_SCOPE_CALIB_CTRL_TIMEOUT_EN adds an ACCUM-stall watchdog.
module rp_scope_calib_ctrl
    import rp_scope_calib_pkg::*;
#(
    parameter int DBITS        = 16,
    parameter int ACC_LOG2_MAX = 16,
    parameter int SETTLE_BITS  = 16
) (
    input  logic                 adc_clk_i,
    input  logic                 adc_rst_i,
    rp_scope_calib_ctrl_if.slave bus
);
    localparam logic signed [DBITS-1:0] SAT_MAX = DBITS'(sat_max(DBITS));
    localparam logic signed [DBITS-1:0] SAT_MIN = DBITS'(sat_min(DBITS));
    localparam logic [4:0]              NMAX    = 5'(ACC_LOG2_MAX);

    state_t                  r_state, w_state_nxt;
    logic [4:0]              r_n;
    logic [SETTLE_BITS-1:0]  r_settle, r_settle_cnt, w_settle_inc;
    logic signed [DBITS-1:0] r_offset, r_meas_avg, w_avg;
    logic [15:0]             r_gain;
    logic                    r_done, r_err;
    logic                    w_start_acc, w_load, w_calc, w_apply, w_timeout;
    logic                    w_last, w_wdog_hit;

    assign w_settle_inc = r_settle_cnt + SETTLE_BITS'(1);

    rp_scope_calib_acc #(.DBITS(DBITS), .ACC_LOG2_MAX(ACC_LOG2_MAX)) u_acc (
        .i_clk    (adc_clk_i),
        .i_rst    (adc_rst_i),
        .i_clr    (w_start_acc),
        .i_en     (r_state == ST_ACCUM),
        .i_tvalid (bus.adc_tvalid_i),
        .i_dat    (bus.adc_dat_i),
        .i_n      (r_n),
        .o_last   (w_last),
        .o_avg    (w_avg)
    );

`ifdef RP_SCOPE_CALIB_CTRL_TIMEOUT_EN
    logic [15:0] r_wdog;

    // Count consecutive idle ACCUM cycles; any valid sample or leaving ACCUM rearms it.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i)
            r_wdog <= '0;
        else if (r_state == ST_ACCUM && !bus.adc_tvalid_i)
            r_wdog <= r_wdog + 16'd1;
        else
            r_wdog <= '0;
    end

    assign w_wdog_hit = (r_state == ST_ACCUM) && !bus.adc_tvalid_i &&
                        (r_wdog == 16'(WDOG_LIMIT - 1));
`else
    assign w_wdog_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) r_state <= ST_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Next-state and per-cycle strobes; abort overrides everything while busy.
    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_load      = 1'b0;
        w_calc      = 1'b0;
        w_apply     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load = bus.load_man_i;
                if (bus.start_i && !bus.abort_i) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = (bus.cfg_settle_i == '0) ? ST_ACCUM : ST_SETTLE;
                end
            end
            ST_SETTLE: if (w_settle_inc == r_settle) w_state_nxt = ST_ACCUM;
            ST_ACCUM: begin
                if (w_last) begin
                    w_state_nxt = ST_CALC;
                end else if (w_wdog_hit) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            ST_CALC: begin
                w_calc      = 1'b1;
                w_state_nxt = ST_APPLY;
            end
            ST_APPLY: begin
                w_apply     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (r_state != ST_IDLE && bus.abort_i) begin
            w_state_nxt = ST_IDLE;
            w_calc      = 1'b0;
            w_apply     = 1'b0;
            w_timeout   = 1'b0;
        end
    end

    // Run configuration latch and settle counter.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            r_n          <= '0;
            r_settle     <= '0;
            r_settle_cnt <= '0;
        end else if (w_start_acc) begin
            r_n          <= (bus.cfg_avg_log2_i > NMAX) ? NMAX : bus.cfg_avg_log2_i;
            r_settle     <= bus.cfg_settle_i;
            r_settle_cnt <= '0;
        end else if (r_state == ST_SETTLE) begin
            r_settle_cnt <= w_settle_inc;
        end
    end

    // Output registers: gain follows config every cycle, offset/avg/flags follow the run.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            r_offset   <= '0;
            r_gain     <= GAIN_UNITY;
            r_meas_avg <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_gain <= bus.cfg_gain_i;
            r_done <= 1'b0;
            if (w_load)      r_offset   <= bus.cfg_offset_man_i;
            if (w_start_acc) r_err      <= 1'b0;
            if (w_calc)      r_meas_avg <= w_avg;
            if (w_timeout)   r_err      <= 1'b1;
            if (w_apply) begin
                r_done <= 1'b1;
                // -SAT_MIN is not representable; clamp and flag it.
                if (r_meas_avg == SAT_MIN) begin
                    r_offset <= SAT_MAX;
                    r_err    <= 1'b1;
                end else begin
                    r_offset <= -r_meas_avg;
                end
            end
        end
    end

    assign bus.cfg_calib_offset_o = r_offset;
    assign bus.cfg_calib_gain_o   = r_gain;
    assign bus.meas_avg_o         = r_meas_avg;
    assign bus.busy_o             = (r_state != ST_IDLE);
    assign bus.done_o             = r_done;
    assign bus.err_o              = r_err;
endmodule

// File: tb/tb_rp_scope_calib_ctrl.sv
// Self-checking bench for rp_scope_calib_ctrl: scoreboard of expected run results.
module tb_rp_scope_calib_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rp_scope_calib_ctrl_if #(.DBITS(16), .SETTLE_BITS(16)) bus ();

    rp_scope_calib_ctrl #(.DBITS(16), .ACC_LOG2_MAX(16), .SETTLE_BITS(16)) dut (
        .adc_clk_i (clk),
        .adc_rst_i (rst),
        .bus       (bus)
    );

    typedef struct {
        logic signed [15:0] off;
        logic signed [15:0] avg;
        logic               err;
        int                 lat;
    } exp_t;

    exp_t               sb[$];
    int                 total = 0;
    int                 bad   = 0;
    logic signed [15:0] m_off = 16'sd0;
    logic               m_err = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic init_inputs();
        bus.adc_dat_i        = '0;
        bus.adc_tvalid_i     = 1'b0;
        bus.start_i          = 1'b0;
        bus.abort_i          = 1'b0;
        bus.load_man_i       = 1'b0;
        bus.cfg_avg_log2_i   = '0;
        bus.cfg_settle_i     = '0;
        bus.cfg_offset_man_i = '0;
        bus.cfg_gain_i       = 16'h1111;
    endtask

    // One auto-offset run; mode 0 = constant a with tvalid always high,
    // mode 1 = valid samples alternating a/b with tvalid toggling (N >= 1).
    task automatic run_auto(input int settle, input int n, input int mode, input int a, input int b,
                            input bit with_load, input logic signed [15:0] man);
        exp_t   e;
        longint sum;
        longint avg;
        int     cyc;
        int     k;
        bit     got;
        sum   = (mode == 0) ? (longint'(a) <<< n) : ((longint'(a) + longint'(b)) <<< (n - 1));
        avg   = sum >>> n;
        e.avg = 16'(avg);
        e.err = (avg == -32768);
        e.off = e.err ? 16'sd32767 : 16'(-avg);
        e.lat = (mode == 0) ? settle + (1 << n) + 2 : -1;
        sb.push_back(e);

        bus.cfg_settle_i   = 16'(settle);
        bus.cfg_avg_log2_i = 5'(n);
        bus.adc_dat_i      = 16'(a);
        bus.adc_tvalid_i   = (mode == 0);
        bus.start_i        = 1'b1;
        if (with_load) begin
            bus.load_man_i       = 1'b1;
            bus.cfg_offset_man_i = man;
        end
        step();
        bus.start_i        = 1'b0;
        bus.load_man_i     = 1'b0;
        bus.cfg_settle_i   = 16'd3;
        bus.cfg_avg_log2_i = 5'd7;
        total++;
        if (bus.busy_o !== 1'b1 || bus.err_o !== 1'b0) begin
            bad++;
            $display("FAIL start_accept: busy=%b err=%b expected busy=1 err=0", bus.busy_o, bus.err_o);
        end
        if (with_load) begin
            chk("load_with_start", bus.cfg_calib_offset_o, man);
            m_off = man;
        end

        k   = 0;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 3000) begin
            if (mode == 0) begin
                bus.adc_tvalid_i = 1'b1;
                bus.adc_dat_i    = 16'(a);
            end else begin
                bus.adc_tvalid_i = (cyc % 2 == 1);
                if (bus.adc_tvalid_i) begin
                    bus.adc_dat_i = 16'((k % 2 == 0) ? a : b);
                    k++;
                end else begin
                    bus.adc_dat_i = 16'sh7fff;
                end
            end
            bus.start_i = (cyc == 2);
            step();
            cyc++;
            if (bus.done_o === 1'b1) got = 1'b1;
        end
        bus.start_i      = 1'b0;
        bus.adc_tvalid_i = 1'b0;

        if (!got) begin
            total++;
            bad++;
            $display("FAIL run_timeout: no done after %0d cycles", cyc);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: done with no expected entry");
        end else begin
            e = sb.pop_front();
            chk("offset", bus.cfg_calib_offset_o, e.off);
            chk("meas_avg", bus.meas_avg_o, e.avg);
            chk("err", bus.err_o, e.err);
            if (e.lat >= 0) chk("latency", cyc, e.lat);
            m_off = e.off;
            m_err = e.err;
        end
        step();
        total++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            bad++;
            $display("FAIL done_single: done=%b busy=%b expected 0 0", bus.done_o, bus.busy_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        chk("rst_offset", bus.cfg_calib_offset_o, 0);
        chk("rst_gain", bus.cfg_calib_gain_o, 16'h8000);
        chk("rst_meas", bus.meas_avg_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_err", bus.err_o, 0);
        rst = 1'b0;
        step();
        chk("gain_after_rst", bus.cfg_calib_gain_o, 16'h1111);
    endtask

    task automatic test_gain();
        bus.cfg_gain_i = 16'h4321;
        #2;
        chk("gain_registered", bus.cfg_calib_gain_o, 16'h1111);
        step();
        chk("gain_follow", bus.cfg_calib_gain_o, 16'h4321);
        bus.cfg_gain_i = 16'h8000;
        step();
    endtask

    task automatic test_avg_basic();
        run_auto(10, 4, 0, -100, 0, 1'b0, 16'sd0);
        run_auto(3, 2, 0, 5, 0, 1'b0, 16'sd0);
    endtask

    task automatic test_stall_floor();
        run_auto(0, 1, 1, 7, 8, 1'b0, 16'sd0);
        run_auto(4, 2, 1, -7, -8, 1'b0, 16'sd0);
    endtask

    task automatic test_saturate();
        run_auto(0, 0, 0, -32768, 0, 1'b0, 16'sd0);
        run_auto(3, 2, 0, 5, 0, 1'b0, 16'sd0);
    endtask

    task automatic test_abort();
        int dn;
        bus.cfg_settle_i   = 16'd2;
        bus.cfg_avg_log2_i = 5'd4;
        bus.adc_dat_i      = 16'sd50;
        bus.adc_tvalid_i   = 1'b1;
        bus.start_i        = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        chk("abort_busy", bus.busy_o, 0);
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.done_o === 1'b1) dn++;
        end
        chk("abort_no_done", dn, 0);
        chk("abort_offset", bus.cfg_calib_offset_o, m_off);
        chk("abort_err", bus.err_o, m_err);
        bus.start_i = 1'b1;
        bus.abort_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        chk("start_abort_idle", bus.busy_o, 0);
        bus.adc_tvalid_i = 1'b0;
        step();
    endtask

    task automatic test_load_man();
        bus.cfg_offset_man_i = 16'sh0123;
        bus.load_man_i       = 1'b1;
        step();
        bus.load_man_i = 1'b0;
        chk("load_idle", bus.cfg_calib_offset_o, 16'sh0123);
        m_off = 16'sh0123;
        bus.cfg_settle_i = 16'd20;
        bus.start_i      = 1'b1;
        step();
        bus.start_i          = 1'b0;
        bus.cfg_offset_man_i = 16'sh0456;
        bus.load_man_i       = 1'b1;
        step();
        bus.load_man_i = 1'b0;
        step();
        chk("load_busy_ignored", bus.cfg_calib_offset_o, 16'sh0123);
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        chk("load_abort_busy", bus.busy_o, 0);
        run_auto(0, 1, 0, 10, 0, 1'b1, 16'sh0777);
    endtask

    task automatic test_back_to_back();
        run_auto(1, 3, 0, 1234, 0, 1'b0, 16'sd0);
        run_auto(0, 0, 0, -32767, 0, 1'b0, 16'sd0);
    endtask

    task automatic test_reset_mid_run();
        bus.cfg_settle_i   = 16'd0;
        bus.cfg_avg_log2_i = 5'd5;
        bus.adc_dat_i      = 16'sd9;
        bus.adc_tvalid_i   = 1'b1;
        bus.start_i        = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        chk("midrst_busy", bus.busy_o, 0);
        chk("midrst_offset", bus.cfg_calib_offset_o, 0);
        chk("midrst_meas", bus.meas_avg_o, 0);
        rst = 1'b0;
        bus.adc_tvalid_i = 1'b0;
        m_off = 16'sd0;
        m_err = 1'b0;
        step();
    endtask

`ifdef RP_SCOPE_CALIB_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        int dn;
        bus.cfg_settle_i   = 16'd0;
        bus.cfg_avg_log2_i = 5'd2;
        bus.adc_tvalid_i   = 1'b0;
        bus.start_i        = 1'b1;
        step();
        bus.start_i = 1'b0;
        cyc = 0;
        dn  = 0;
        while (bus.busy_o === 1'b1 && cyc < 70000) begin
            step();
            cyc++;
            if (bus.done_o === 1'b1) dn++;
        end
        chk("wdog_cycles", cyc, 65535);
        chk("wdog_err", bus.err_o, 1);
        chk("wdog_no_done", dn, 0);
        chk("wdog_offset", bus.cfg_calib_offset_o, m_off);
        m_err = 1'b1;
    endtask
`endif

    initial begin
        init_inputs();
        test_reset();
        test_gain();
        test_avg_basic();
        test_stall_floor();
        test_saturate();
        test_abort();
        test_load_man();
        test_back_to_back();
        test_reset_mid_run();
`ifdef RP_SCOPE_CALIB_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rp_scope_calib_ctrl.md
Name: rp_scope_calib_ctrl

Overview:
Auto-offset calibration sequencer for one scope channel, sitting in front of the channel's calibration datapath (offset add, gain multiply, saturate).
- On command it waits a settle time, then averages 2^N raw ADC samples with the input grounded.
- It writes the negated average as the calibration offset and drives the gain word.
- Also supports manual offset/gain loads from the register bank.

Parameters:
DBITS, 16, ADC sample width (signed two's complement).
ACC_LOG2_MAX, 16, maximum log2 of averaged sample count; accumulator width = DBITS+ACC_LOG2_MAX.
SETTLE_BITS, 16, width of settle-time counter.

Ports:
adc_clk_i  in  1  ADC clock; all logic on rising edge.
adc_rst_i  in  1  synchronous reset, active high.
adc_dat_i  in  DBITS  raw signed ADC sample (pre-calibration).
adc_tvalid_i  in  1  sample valid qualifier.
start_i  in  1  single-cycle pulse: begin auto-offset run.
abort_i  in  1  single-cycle pulse: cancel run.
load_man_i  in  1  single-cycle pulse: load manual offset and gain.
cfg_avg_log2_i  in  5  log2 of sample count N.
cfg_settle_i  in  SETTLE_BITS  settle time in clock cycles.
cfg_offset_man_i  in  DBITS  manual offset value.
cfg_gain_i  in  16  gain word (unsigned, 0x8000 = unity).
cfg_calib_offset_o  out  DBITS  offset to calibration datapath.
cfg_calib_gain_o  out  16  gain to calibration datapath.
meas_avg_o  out  DBITS  last measured average.
busy_o  out  1  high in any state other than IDLE.
done_o  out  1  single-cycle pulse on successful completion.
err_o  out  1  sticky error; cleared by accepted start_i.

Behaviour:
- Reset values: offset 0, gain 16'h8000, meas_avg 0, busy 0, done 0, err 0, state IDLE, counters and accumulator 0.
- States: IDLE, SETTLE, ACCUM, CALC, APPLY.
- IDLE:
  - start_i → latch N = min(cfg_avg_log2_i, ACC_LOG2_MAX) and settle count; clear accumulator and err_o.
  - Next state is SETTLE, or ACCUM if cfg_settle_i == 0.
- SETTLE:
  - Counts clock cycles regardless of adc_tvalid_i.
  - Moves to ACCUM after exactly cfg_settle_i cycles in SETTLE.
- ACCUM:
  - Sign-extends and adds adc_dat_i only on cycles with adc_tvalid_i = 1; tvalid low stalls the count.
  - Moves to CALC after the 2^N-th accepted sample.
- CALC (1 cycle): avg = accumulator >>> N (arithmetic, floor); registered into meas_avg_o.
- APPLY (1 cycle):
  - cfg_calib_offset_o <= -avg, saturated to [-(2^(DBITS-1)), 2^(DBITS-1)-1].
  - If avg == -(2^(DBITS-1)), output 2^(DBITS-1)-1 and set err_o.
  - done_o pulses on the same edge the offset updates; return to IDLE.
- Latency: settle + 2^N valid samples + 2 cycles from start acceptance to done.
- start_i while busy_o = 1: ignored.
- abort_i:
  - In any busy state: go to IDLE next cycle; outputs keep old values; no done_o; err_o unchanged.
  - Simultaneous with start_i in IDLE: abort wins, start ignored.
- load_man_i:
  - Accepted only in IDLE: offset <= cfg_offset_man_i next cycle.
  - Ignored when busy.
  - load_man_i together with start_i: manual load applied, then run starts.
- cfg_calib_gain_o: registers cfg_gain_i every cycle (1-cycle latency) independent of state.
- Changes to cfg_avg_log2_i / cfg_settle_i during a run have no effect.
- Accumulator cannot overflow by construction (width rule).
- Reset mid-run: immediate return to reset values.

Optional Feature:
RP_SCOPE_CALIB_CTRL_TIMEOUT_EN
- Defined: 16-bit watchdog counts consecutive ACCUM cycles with adc_tvalid_i = 0, resetting on every valid sample.
- At 65535 it returns to IDLE, sets err_o, gives no done_o and leaves outputs unchanged.
- Undefined: ACCUM waits indefinitely; no watchdog logic.

Decomposition:
- Shared package rp_scope_calib_pkg: state enum type, GAIN_UNITY = 16'h8000, SAT_MAX/SAT_MIN functions of DBITS, WDOG_LIMIT = 65535.
- One natural sub-module rp_scope_calib_acc: accumulator, sample counter and shift-average.
- FSM and output registers stay in the top.

Test Plan:
- Reset → offset 0, gain 0x8000, busy 0, done 0, err 0.
- adc_dat_i = -100 constant, tvalid 1, N = 4, settle 10 → done 10+16+2 cycles after start; offset = +100; meas_avg = -100.
- Alternating 7/8, N = 1, tvalid toggling 1/0 → accumulation stalls on tvalid 0; avg = 7 (floor of 7.5); offset = -7.
- adc_dat_i = -32768, N = 0 → offset = 32767, err_o = 1; next start clears err_o.
- abort_i mid-ACCUM → busy 0 next cycle, no done pulse, offset unchanged; start+abort same cycle in IDLE → stays IDLE.
- load_man_i with cfg_offset_man_i = 0x0123 in IDLE → offset 0x0123 next cycle; while busy → ignored. TIMEOUT_EN build: tvalid held 0 in ACCUM → err_o after 65535 cycles.
